// File: rtl/pgm_video_timing.sv
// -----------------------------------------------------------------------------
// pgm_video_timing
//   Parametrised raster timing generator for the PGM video path. It advances a
//   pixel/line counter pair on every clock where ce_pix_i is high. It also
//   produces sync, blanking and display-enable levels, a line-prefetch request
//   for the sprite/tile line buffers, a vblank interrupt pulse for the 68k and
//   a completed-frame counter.
//
// Ports
//   clk_vid_i      in   1      video clock, all logic on the rising edge
//   reset_i        in   1      synchronous, active-high reset
//   ce_pix_i       in   1      pixel enable; timing advances only when high
//   h_cnt_o        out  CNT_W  current pixel column, 0..H_TOTAL-1
//   v_cnt_o        out  CNT_W  current line, 0..V_TOTAL-1
//   hs_o / vs_o    out  1      horizontal / vertical sync at configured polarity
//   hblank_o       out  1      h_cnt >= H_ACTIVE
//   vblank_o       out  1      v_cnt >= V_ACTIVE
//   de_o           out  1      display enable (~hblank & ~vblank)
//   line_req_o     out  1      one-clock pulse: fetch the next visible line now
//   line_req_v_o   out  CNT_W  line number being requested, held between pulses
//   vblank_irq_o   out  1      one-clock pulse on entry to vblank
//   frame_cnt_o    out  16     frames completed since reset, wrapping
// -----------------------------------------------------------------------------
module pgm_video_timing #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOOKAHEAD = 64,
    parameter int CNT_W     = 11
) (
    input  logic             clk_vid_i,
    input  logic             reset_i,
    input  logic             ce_pix_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             hblank_o,
    output logic             vblank_o,
    output logic             de_o,
    output logic             line_req_o,
    output logic [CNT_W-1:0] line_req_v_o,
    output logic             vblank_irq_o,
    output logic [15:0]      frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_REQ    = CNT_W'(H_TOTAL - LOOKAHEAD);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};

    // Reject configurations the counters or the prefetch window cannot represent.
    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
        $error("pgm_video_timing: H_ACTIVE and V_ACTIVE must be at least 1");
    end
    if (LOOKAHEAD < 1 || LOOKAHEAD > H_FP + H_SYNC + H_BP) begin : g_bad_lookahead
        $error("pgm_video_timing: LOOKAHEAD must lie in 1..H_FP+H_SYNC+H_BP");
    end
    if (CNT_W < 2 || CNT_W > 30 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
        $error("pgm_video_timing: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d, nv_s;
    logic [CNT_W-1:0] line_req_v_q, line_req_v_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
    logic             line_req_q, line_req_d, irq_q, irq_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    // Set by reset; suppresses the frame count on the step out of the reset position.
    logic             first_q, first_d;

    // Line that follows the one the counters are about to sit on.
    assign nv_s = (v_d == V_LAST) ? ZERO : v_d + ONE;

    // Next counter position, pulses and frame count for this clock.
    always_comb begin
        h_d          = h_q;
        v_d          = v_q;
        first_d      = first_q;
        frame_cnt_d  = frame_cnt_q;
        line_req_d   = 1'b0;
        line_req_v_d = line_req_v_q;
        irq_d        = 1'b0;
        if (ce_pix_i) begin
            first_d = 1'b0;
            if (h_q == H_LAST) begin
                h_d = ZERO;
                v_d = (v_q == V_LAST) ? ZERO : v_q + ONE;
            end else begin
                h_d = h_q + ONE;
                v_d = v_q;
            end
            if (h_q == H_LAST && v_q == V_LAST && !first_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
            // Prefetch only when the following line is a visible one.
            if (h_d == H_REQ && nv_s < V_ACT) begin
                line_req_d   = 1'b1;
                line_req_v_d = nv_s;
            end else begin
                line_req_d   = 1'b0;
                line_req_v_d = line_req_v_q;
            end
            irq_d = (h_d == ZERO) && (v_d == V_ACT);
        end else begin
            line_req_d = 1'b0;
            irq_d      = 1'b0;
        end
    end

    // Levels are decoded from the next count so they register alongside it.
    always_comb begin
        hs_d     = (h_d >= H_SYNC_S && h_d < H_SYNC_E) ? HS_POL : ~HS_POL;
        vs_d     = (v_d >= V_SYNC_S && v_d < V_SYNC_E) ? VS_POL : ~VS_POL;
        hblank_d = (h_d >= H_ACT);
        vblank_d = (v_d >= V_ACT);
        de_d     = ~hblank_d & ~vblank_d;
    end

    // State and output registers with synchronous reset to the last raster position.
    always_ff @(posedge clk_vid_i) begin
        if (reset_i) begin
            h_q          <= H_LAST;
            v_q          <= V_LAST;
            hs_q         <= ~HS_POL;
            vs_q         <= ~VS_POL;
            hblank_q     <= 1'b1;
            vblank_q     <= 1'b1;
            de_q         <= 1'b0;
            line_req_q   <= 1'b0;
            line_req_v_q <= ZERO;
            irq_q        <= 1'b0;
            frame_cnt_q  <= 16'd0;
            first_q      <= 1'b1;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            hblank_q     <= hblank_d;
            vblank_q     <= vblank_d;
            de_q         <= de_d;
            line_req_q   <= line_req_d;
            line_req_v_q <= line_req_v_d;
            irq_q        <= irq_d;
            frame_cnt_q  <= frame_cnt_d;
            first_q      <= first_d;
        end
    end

    assign h_cnt_o      = h_q;
    assign v_cnt_o      = v_q;
    assign hs_o         = hs_q;
    assign vs_o         = vs_q;
    assign hblank_o     = hblank_q;
    assign vblank_o     = vblank_q;
    assign de_o         = de_q;
    assign line_req_o   = line_req_q;
    assign line_req_v_o = line_req_v_q;
    assign vblank_irq_o = irq_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
